uart_rx_fifo: RTL
=================

// Module: uart_rx_fifo
// PURPOSE
//  Receive-side byte buffer directly downstream of the UART receiver; consumes its
//  one-cycle data-valid strobe and byte. Holds bytes in a first-word-fall-through FIFO
//  for the APB register layer. Provides level/threshold status, a sticky overflow flag,
//  and a character-timeout flag for partial bursts left below threshold.
// PARAMETERS
//  DEPTH         16    FIFO entries; power of 2, >= 2
//  THRESH        8     o_Thresh asserts when level >= THRESH; 1..DEPTH
//  TIMEOUT_CLKS  3480  idle clocks (about 4 chars at 87 clks/bit) before o_Timeout; >= 2
// PORTS
//  i_Clock      in   1              system clock; all logic on posedge
//  i_Reset      in   1              synchronous, active-high reset
//  i_Rx_DV      in   1              one-cycle strobe: i_Rx_Byte valid (push request)
//  i_Rx_Byte    in   8              received byte
//  i_Rd_En      in   1              pop request; head byte consumed this cycle
//  i_Clr_Ovf    in   1              clears o_Overflow
//  o_Rd_Byte    out  8              head-of-FIFO byte; valid while o_Empty==0
//  o_Empty      out  1              level == 0
//  o_Full       out  1              level == DEPTH
//  o_Level      out  $clog2(DEPTH)+1  bytes held, 0..DEPTH
//  o_Thresh     out  1              level >= THRESH
//  o_Overflow   out  1              sticky: a byte was dropped
//  o_Timeout    out  1              non-empty FIFO idle for TIMEOUT_CLKS clocks
// BEHAVIOUR
//  Reset: pointers=0, level=0, o_Empty=1, o_Full=0, o_Thresh=0, o_Overflow=0,
//   o_Timeout=0, timeout FSM=T_IDLE. o_Rd_Byte=don't-care while empty.
//  Memory: DEPTH x 8 register array; rd/wr pointers $clog2(DEPTH) bits, natural wrap.
//  Status outputs registered; all update the cycle after the causing edge.
//  push = i_Rx_DV & (~o_Full | i_Rd_En);  pop = i_Rd_En & ~o_Empty.
//  Push latency: byte written at edge N; o_Empty falls, o_Rd_Byte valid after edge N.
//  FWFT: o_Rd_Byte = mem[rd_ptr] read asynchronously from the array; a pop advances
//   rd_ptr, next byte visible after the same edge.
//  Push+pop same cycle: level unchanged, both pointers advance.
//  Full + i_Rx_DV + i_Rd_En: pop frees a slot; byte accepted, no overflow.
//  Full + i_Rx_DV, no i_Rd_En: byte dropped, contents unchanged, o_Overflow set.
//  Empty + i_Rd_En: ignored, no pointer movement. Empty + push + rd: push only, level=1.
//  o_Overflow: set on drop; cleared by i_Clr_Ovf; set wins if both in same cycle.
//  Timeout FSM (counter width $clog2(TIMEOUT_CLKS)+1):
//   T_IDLE:    cnt=0. Go to T_COUNT when level != 0 after an edge.
//   T_COUNT:   cnt=0 on any push or pop, else cnt+1. Reaching TIMEOUT_CLKS-1 with no
//              push/pop -> T_EXPIRED and o_Timeout=1. Level reaches 0 -> T_IDLE.
//   T_EXPIRED: o_Timeout held. Any push or pop -> T_COUNT with cnt=0 and o_Timeout=0;
//              level reaches 0 -> T_IDLE.
//  o_Timeout is never 1 while o_Empty=1.
//  i_Reset mid-operation: contents discarded, all state to reset values next edge;
//   i_Rx_DV in the reset cycle is ignored.
// TESTING
//  1 Push 0xA5 then 0x3C, no reads -> o_Level=2, o_Rd_Byte=0xA5, o_Empty=0.
//    Pop -> 0x3C at head; pop again -> o_Empty=1, o_Level=0.
//  2 Push 16 bytes 0x00..0x0F (DEPTH=16) -> o_Full=1, o_Thresh=1 from the 8th push.
//    Push 0xFF -> dropped, o_Overflow=1; drain reads 0x00..0x0F in order.
//  3 Full FIFO, i_Rx_DV(0x77) with i_Rd_En in same cycle -> no overflow, o_Level=16,
//    0x77 read last. Hold i_Clr_Ovf with a drop in the same cycle -> o_Overflow stays 1.
//  4 Push one byte, idle -> o_Timeout=1 exactly TIMEOUT_CLKS cycles after the push
//    (±1 per FSM entry). Pop -> o_Timeout=0, o_Empty=1. Re-push at cycle 3000 -> timer restarts.
//  5 Wrap: 40 interleaved push/pop pairs, level kept at 3 -> bytes in order, pointers wrap cleanly.
//  6 Assert i_Reset with 5 bytes held and o_Overflow=1 -> next cycle o_Empty=1,
//    o_Level=0, o_Overflow=0, o_Timeout=0.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT byte FIFO behind the UART receiver, with level/threshold status,
// a sticky overflow flag and a character-timeout flag for idle partial bursts.
module uart_rx_fifo #(
  parameter int DEPTH        = 16,
  parameter int THRESH       = 8,
  parameter int TIMEOUT_CLKS = 3480
) (
  input  logic                     i_Clock,
  input  logic                     i_Reset,
  input  logic                     i_Rx_DV,
  input  logic [7:0]               i_Rx_Byte,
  input  logic                     i_Rd_En,
  input  logic                     i_Clr_Ovf,
  output logic [7:0]               o_Rd_Byte,
  output logic                     o_Empty,
  output logic                     o_Full,
  output logic [$clog2(DEPTH):0]   o_Level,
  output logic                     o_Thresh,
  output logic                     o_Overflow,
  output logic                     o_Timeout
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(TIMEOUT_CLKS) + 1;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_THR  = LVL_W'(THRESH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CLKS - 1);

  typedef enum logic [1:0] {T_IDLE, T_COUNT, T_EXPIRED} tstate_t;

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0] level, level_nxt;
  logic             empty, full, thresh, ovf, timeout, timeout_nxt;
  logic             push, pop, drop;
  tstate_t          state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign push      = i_Rx_DV & (~full | i_Rd_En);
  assign pop       = i_Rd_En & ~empty;
  assign drop      = i_Rx_DV & ~push;
  assign level_nxt = level + LVL_W'(push) - LVL_W'(pop);

  always_ff @(posedge i_Clock) begin
    if (push) mem[wr_ptr] <= i_Rx_Byte;
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      empty   <= 1'b1;
      full    <= 1'b0;
      thresh  <= 1'b0;
      ovf     <= 1'b0;
      state   <= T_IDLE;
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      level   <= level_nxt;
      empty   <= (level_nxt == '0);
      full    <= (level_nxt == LVL_FULL);
      thresh  <= (level_nxt >= LVL_THR);
      // A drop in the same cycle as a clear keeps the flag set.
      ovf     <= drop | (ovf & ~i_Clr_Ovf);
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      timeout <= timeout_nxt;
    end
  end

  // Timeout FSM follows the post-edge level so it can never flag an empty FIFO.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      T_IDLE: begin
        cnt_nxt = '0;
        if (level_nxt != '0) state_nxt = T_COUNT;
      end
      T_COUNT: begin
        if (level_nxt == '0) begin
          state_nxt = T_IDLE;
          cnt_nxt   = '0;
        end else if (push | pop) begin
          cnt_nxt = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = T_EXPIRED;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      T_EXPIRED: begin
        cnt_nxt = '0;
        if (level_nxt == '0)  state_nxt = T_IDLE;
        else if (push | pop)  state_nxt = T_COUNT;
      end
      default: begin
        state_nxt = T_IDLE;
        cnt_nxt   = '0;
      end
    endcase
    timeout_nxt = (state_nxt == T_EXPIRED);
  end

  assign o_Rd_Byte  = mem[rd_ptr];
  assign o_Empty    = empty;
  assign o_Full     = full;
  assign o_Level    = level;
  assign o_Thresh   = thresh;
  assign o_Overflow = ovf;
  assign o_Timeout  = timeout;

endmodule
